// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, frame-buffer geometry and shared sync types.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;   // 800

  // Vertical timing in lines
  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;   // 525

  // Frame buffer is the visible area downscaled by 2 in each axis
  localparam int FB_W = 320;
  localparam int FB_H = 240;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 17;

  // Per-pixel control outputs, kept together so they are registered as one word
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic valid;
    logic frame_start;
  } sync_t;

  // Syncs idle high, nothing visible, no frame marker
  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, valid: 1'b0, frame_start: 1'b0};

endpackage

// File: rtl/vga_addr_gen.sv
// Maps a raster position to a 320x240 frame-buffer address (2x2 pixel replication).
// Latency: combinational; the caller registers the result alongside the counters.
// Backpressure: none, pure function of its inputs.
module vga_addr_gen
  import vga_pkg::*;
(
  input  logic [CNT_W-1:0]  i_h_nxt,
  input  logic [CNT_W-1:0]  i_v_nxt,
  input  logic              i_valid_nxt,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_row_x256;
  logic [ADDR_W-1:0] w_row_x64;
  logic [ADDR_W-1:0] w_sum;

  // col + row*320, with 320 = 256 + 64 so only shifts and adds are used.
  // Every term is widened to 17 bits before summing; even outside the
  // visible area the raw sum stays below 2^17, so nothing wraps.
  always_comb begin
    w_col      = ADDR_W'(i_h_nxt >> 1);
    w_row      = ADDR_W'(i_v_nxt >> 1);
    w_row_x256 = w_row << 8;
    w_row_x64  = w_row << 6;
    w_sum      = w_col + w_row_x256 + w_row_x64;
    o_addr     = i_valid_nxt ? w_sum : '0;
  end

endmodule

// File: rtl/vga_controller.sv
// VGA raster generator: pixel/line counters, active-low syncs, visible flag, frame marker, FB address.
// Latency: all outputs registered from next-state counts, so they align with h_cnt/v_cnt in the same cycle.
// Backpressure: none; free-running on the pixel clock.
module vga_controller #(
  parameter int H_DISP = vga_pkg::H_DISP,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_DISP = vga_pkg::V_DISP,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         valid,
  output logic [vga_pkg::CNT_W-1:0]    h_cnt,
  output logic [vga_pkg::CNT_W-1:0]    v_cnt,
  output logic                         frame_start,
  output logic [vga_pkg::ADDR_W-1:0]   pixel_addr
);
  import vga_pkg::*;

  localparam int H_TOT  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_DISP + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG = V_DISP + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC - 1;

  logic [CNT_W-1:0]  r_h_cnt;
  logic [CNT_W-1:0]  r_v_cnt;
  logic [CNT_W-1:0]  w_h_nxt;
  logic [CNT_W-1:0]  w_v_nxt;
  logic              w_h_wrap;
  logic              w_v_wrap;
  sync_t             r_sync;
  sync_t             w_sync_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] r_pixel_addr;

  // Next raster position: column always advances, line advances on column wrap
  always_comb begin
    w_h_wrap = (r_h_cnt == CNT_W'(H_TOT - 1));
    w_v_wrap = (r_v_cnt == CNT_W'(V_TOT - 1));
    w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
    end
  end

  // Decode sync/visible/frame flags from the position about to be registered
  always_comb begin
    w_sync_nxt             = SYNC_IDLE;
    w_sync_nxt.hsync       = !((w_h_nxt >= CNT_W'(HS_BEG)) && (w_h_nxt <= CNT_W'(HS_END)));
    w_sync_nxt.vsync       = !((w_v_nxt >= CNT_W'(VS_BEG)) && (w_v_nxt <= CNT_W'(VS_END)));
    w_sync_nxt.valid       = (w_h_nxt < CNT_W'(H_DISP)) && (w_v_nxt < CNT_W'(V_DISP));
    w_sync_nxt.frame_start = (w_h_nxt == '0) && (w_v_nxt == '0);
  end

  vga_addr_gen u_addr_gen (
    .i_h_nxt     (w_h_nxt),
    .i_v_nxt     (w_v_nxt),
    .i_valid_nxt (w_sync_nxt.valid),
    .o_addr      (w_addr_nxt)
  );

  // Counters and outputs share one register stage. Reset parks the counters on
  // the last pixel of the frame so the first edge after release lands on (0,0);
  // syncs reset straight to their idle-high level, so reset never pulses them low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt      <= CNT_W'(H_TOT - 1);
      r_v_cnt      <= CNT_W'(V_TOT - 1);
      r_sync       <= SYNC_IDLE;
      r_pixel_addr <= '0;
    end else begin
      r_h_cnt      <= w_h_nxt;
      r_v_cnt      <= w_v_nxt;
      r_sync       <= w_sync_nxt;
      r_pixel_addr <= w_addr_nxt;
    end
  end

  assign h_cnt       = r_h_cnt;
  assign v_cnt       = r_v_cnt;
  assign hsync       = r_sync.hsync;
  assign vsync       = r_sync.vsync;
  assign valid       = r_sync.valid;
  assign frame_start = r_sync.frame_start;
  assign pixel_addr  = r_pixel_addr;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: default-timing instance, reduced-timing instance, and address-generator probe.
// Latency: expected values queued per edge and compared #1 after that edge.
// Backpressure: n/a; fixed cycle budget, always terminates.
module tb_vga_controller;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit vld;
    bit fs;
    int addr;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst_s;

  logic        d_hs, d_vs, d_vld, d_fs;
  logic [9:0]  d_h, d_v;
  logic [16:0] d_addr;
  logic        s_hs, s_vs, s_vld, s_fs;
  logic [9:0]  s_h, s_v;
  logic [16:0] s_addr;
  logic [9:0]  p_h, p_v;
  logic        p_vld;
  logic [16:0] p_addr;

  int n_assert;
  int n_fail;
  int cyc;
  exp_t q_d[$];
  exp_t q_s[$];

  // reference raster positions
  int dh, dv, sh, sv;

  // measurement state
  bit prev_hs_d, prev_vld_d, prev_vs_s, fs_seen;
  int hs_run, vs_run, last_fs;
  int prev_sh, prev_sv;

  vga_controller dut (
    .clk(clk), .rst_n(rst_n), .hsync(d_hs), .vsync(d_vs), .valid(d_vld),
    .h_cnt(d_h), .v_cnt(d_v), .frame_start(d_fs), .pixel_addr(d_addr)
  );

  // 24 x 14 raster: sync 18..21, vsync lines 10..11, frame = 336 clocks
  vga_controller #(
    .H_DISP(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_DISP(8),  .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_s), .hsync(s_hs), .vsync(s_vs), .valid(s_vld),
    .h_cnt(s_h), .v_cnt(s_v), .frame_start(s_fs), .pixel_addr(s_addr)
  );

  vga_addr_gen u_probe (
    .i_h_nxt(p_h), .i_v_nxt(p_v), .i_valid_nxt(p_vld), .o_addr(p_addr)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_out(int h, int v, int hd, int hf, int hsw, int vd, int vf, int vsw);
    exp_t e;
    e.h    = h;
    e.v    = v;
    e.hs   = !(h >= hd + hf && h < hd + hf + hsw);
    e.vs   = !(v >= vd + vf && v < vd + vf + vsw);
    e.vld  = (h < hd) && (v < vd);
    e.fs   = (h == 0) && (v == 0);
    e.addr = e.vld ? (h / 2) + 320 * (v / 2) : 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cmp(input string p, input exp_t e, input logic [9:0] h, input logic [9:0] v,
                     input logic hs, input logic vs, input logic vld, input logic fs,
                     input logic [16:0] a);
    chk({p, ".h_cnt"}, 32'(h), e.h);
    chk({p, ".v_cnt"}, 32'(v), e.v);
    chk({p, ".hsync"}, 32'(hs), 32'(e.hs));
    chk({p, ".vsync"}, 32'(vs), 32'(e.vs));
    chk({p, ".valid"}, 32'(vld), 32'(e.vld));
    chk({p, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({p, ".pixel_addr"}, 32'(a), e.addr);
  endtask

  task automatic tick();
    exp_t e;
    if (rst_n) begin
      if (dh == 799) begin dh = 0; dv = (dv == 524) ? 0 : dv + 1; end
      else dh = dh + 1;
    end else begin
      dh = 799; dv = 524;
    end
    q_d.push_back(model_out(dh, dv, 640, 16, 96, 480, 10, 2));
    if (rst_s) begin
      if (sh == 23) begin sh = 0; sv = (sv == 13) ? 0 : sv + 1; end
      else sh = sh + 1;
    end else begin
      sh = 23; sv = 13;
    end
    q_s.push_back(model_out(sh, sv, 16, 2, 4, 8, 2, 2));

    @(posedge clk);
    #1;
    cyc++;
    e = q_d.pop_front();
    cmp("d", e, d_h, d_v, d_hs, d_vs, d_vld, d_fs, d_addr);
    e = q_s.pop_front();
    cmp("s", e, s_h, s_v, s_hs, s_vs, s_vld, s_fs, s_addr);

    // default raster: sync pulse placement/width, end of visible span, one address probe
    if (rst_n) begin
      if (!d_hs) begin
        if (prev_hs_d) chk("d.hsync_start_col", 32'(d_h), 656);
        hs_run++;
      end else begin
        if (!prev_hs_d) chk("d.hsync_width", hs_run, 96);
        hs_run = 0;
      end
      if (prev_vld_d && !d_vld) chk("d.valid_end_col", 32'(d_h), 640);
      if (d_h == 10'd3 && d_v == 10'd2) chk("d.addr_3_2", 32'(d_addr), 321);
      prev_hs_d  = d_hs;
      prev_vld_d = d_vld;
    end

    // reduced raster: frame period, vsync window, last-pixel wrap
    if (rst_s) begin
      if (s_fs) begin
        if (fs_seen) chk("s.frame_period", cyc - last_fs, 336);
        fs_seen = 1;
        last_fs = cyc;
      end
      if (!s_vs) begin
        if (prev_vs_s) begin
          chk("s.vsync_start_line", 32'(s_v), 10);
          chk("s.vsync_start_col", 32'(s_h), 0);
        end
        vs_run++;
      end else begin
        if (!prev_vs_s) chk("s.vsync_width", vs_run, 48);
        vs_run = 0;
      end
      if (prev_sh == 23 && prev_sv == 13) begin
        chk("s.wrap_h", 32'(s_h), 0);
        chk("s.wrap_v", 32'(s_v), 0);
        chk("s.wrap_fs", 32'(s_fs), 1);
      end
      prev_vs_s = s_vs;
      prev_sh   = int'(s_h);
      prev_sv   = int'(s_v);
    end
  endtask

  initial begin
    int h;
    int v;
    n_assert = 0; n_fail = 0; cyc = 0;
    clk = 0; rst_n = 1; rst_s = 1;
    dh = 799; dv = 524; sh = 23; sv = 13;
    prev_hs_d = 1; prev_vld_d = 0; prev_vs_s = 1; fs_seen = 0;
    hs_run = 0; vs_run = 0; last_fs = 0; prev_sh = -1; prev_sv = -1;
    p_h = '0; p_v = '0; p_vld = 0;

    // asynchronous reset before any clock edge
    #2;
    rst_n = 0; rst_s = 0;
    #1;
    chk("rst.h_cnt", 32'(d_h), 799);
    chk("rst.v_cnt", 32'(d_v), 524);
    chk("rst.hsync", 32'(d_hs), 1);
    chk("rst.vsync", 32'(d_vs), 1);
    chk("rst.valid", 32'(d_vld), 0);
    chk("rst.frame_start", 32'(d_fs), 0);
    chk("rst.pixel_addr", 32'(d_addr), 0);
    repeat (3) tick();

    // release: first edge lands on (0,0) with frame_start and valid
    rst_n = 1; rst_s = 1;
    tick();
    chk("first.frame_start", 32'(d_fs), 1);
    chk("first.valid", 32'(d_vld), 1);

    // two full lines and into the third
    repeat (2000) tick();
    chk("pre_reset.h", 32'(d_h), 400);
    chk("pre_reset.v", 32'(d_v), 2);

    // mid-frame reset takes effect between edges
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst.h_cnt", 32'(d_h), 799);
    chk("mid_rst.v_cnt", 32'(d_v), 524);
    chk("mid_rst.hsync", 32'(d_hs), 1);
    chk("mid_rst.vsync", 32'(d_vs), 1);
    chk("mid_rst.valid", 32'(d_vld), 0);
    chk("mid_rst.frame_start", 32'(d_fs), 0);
    chk("mid_rst.pixel_addr", 32'(d_addr), 0);
    prev_hs_d = 1; prev_vld_d = 0; hs_run = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    chk("rerelease.frame_start", 32'(d_fs), 1);
    chk("rerelease.h_cnt", 32'(d_h), 0);
    repeat (900) tick();

    // address generator corners and random visible pixels
    p_h = 10'd639; p_v = 10'd479; p_vld = 1; #1;
    chk("probe.addr_639_479", 32'(p_addr), 76799);
    p_h = 10'd3; p_v = 10'd2; p_vld = 1; #1;
    chk("probe.addr_3_2", 32'(p_addr), 321);
    p_h = 10'd640; p_v = 10'd0; p_vld = 0; #1;
    chk("probe.addr_640", 32'(p_addr), 0);
    p_h = 10'd799; p_v = 10'd524; p_vld = 0; #1;
    chk("probe.addr_blank", 32'(p_addr), 0);
    for (int i = 0; i < 24; i++) begin
      h = int'($urandom_range(639, 0));
      v = int'($urandom_range(479, 0));
      p_h = 10'(h); p_v = 10'(v); p_vld = 1; #1;
      chk("probe.addr_rand", 32'(p_addr), (h / 2) + 320 * (v / 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
